enemy_formation_move: RTL

- Successor to the single-enemy mover. Moves a NUM_ROWS x NUM_COLS grid of enemies as one formation.
- Motion is horizontal, in fixed point. On reaching a screen edge the formation steps down and reverses direction.
- Tracks a per-enemy alive mask that shot hits clear.
- Sits between the VGA pixel counters and the enemy bitmap/draw mux. Drives pixel request, offset and index of the enemy under the current pixel.

---
 rtl/enemy_pkg.sv | 20 ++
 rtl/enemy_formation_move_if.sv | 29 ++
 rtl/enemy_extent.sv | 54 +++++
 rtl/enemy_formation_move.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/enemy_pkg.sv
// Shared definitions for the enemy formation mover.
//   FP_SHIFT : fixed-point fraction bits of the position registers (factor 64)
//   state_t  : formation motion states
//   idx()    : flat enemy index from (row, col)
package enemy_pkg;

    localparam int FP_SHIFT = 6;

    typedef enum logic [1:0] {
        S_MOVE,
        S_DROP,
        S_LANDED,
        S_CLEARED
    } state_t;

    function automatic int idx(input int r, input int c, input int ncols);
        return r * ncols + c;
    endfunction

endpackage

// File: rtl/enemy_formation_move_if.sv
// Pixel / hit bus between the VGA side and the enemy formation mover.
//   pixelX, pixelY     : current VGA pixel
//   hitValid, hitIndex : one-cycle shot hit on enemy hitIndex
//   drawingRequest     : pixel lies inside a live enemy (registered)
//   enemyIndex         : index of the enemy under the pixel
//   offsetX, offsetY   : pixel offset inside that enemy
// master = VGA / shot side, slave = formation mover.
interface enemy_formation_move_if;

    logic [10:0] pixelX;
    logic [10:0] pixelY;
    logic        hitValid;
    logic [4:0]  hitIndex;
    logic        drawingRequest;
    logic [4:0]  enemyIndex;
    logic [10:0] offsetX;
    logic [10:0] offsetY;

    modport master (
        output pixelX, pixelY, hitValid, hitIndex,
        input  drawingRequest, enemyIndex, offsetX, offsetY
    );

    modport slave (
        input  pixelX, pixelY, hitValid, hitIndex,
        output drawingRequest, enemyIndex, offsetX, offsetY
    );

endinterface

// File: rtl/enemy_extent.sv
// Combinational live extent of the formation.
//   aliveMask : bit r*NUM_COLS+c set = enemy (r,c) alive
//   minCol    : lowest column holding a live enemy
//   maxCol    : highest column holding a live enemy
//   maxRow    : highest row holding a live enemy
//   anyAlive  : at least one enemy alive (extent values are 0 otherwise)
module enemy_extent
    import enemy_pkg::*;
#(
    parameter int NUM_ROWS = 3,
    parameter int NUM_COLS = 6
) (
    input  logic [NUM_ROWS*NUM_COLS-1:0] aliveMask,
    output logic [2:0]                   minCol,
    output logic [2:0]                   maxCol,
    output logic [1:0]                   maxRow,
    output logic                         anyAlive
);

    logic [NUM_COLS-1:0] col_alive;
    logic [NUM_ROWS-1:0] row_alive;

    always_comb begin
        col_alive = '0;
        row_alive = '0;
        for (int r = 0; r < NUM_ROWS; r++) begin
            for (int c = 0; c < NUM_COLS; c++) begin
                if (aliveMask[idx(r, c, NUM_COLS)]) begin
                    col_alive[c] = 1'b1;
                    row_alive[r] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        minCol = '0;
        maxCol = '0;
        maxRow = '0;
        // Descending scan so the last hit is the lowest live column.
        for (int c = NUM_COLS - 1; c >= 0; c--) begin
            if (col_alive[c]) minCol = 3'(c);
        end
        for (int c = 0; c < NUM_COLS; c++) begin
            if (col_alive[c]) maxCol = 3'(c);
        end
        for (int r = 0; r < NUM_ROWS; r++) begin
            if (row_alive[r]) maxRow = 2'(r);
        end
    end

    assign anyAlive = |aliveMask;

endmodule

// File: rtl/enemy_formation_move.sv
// Moves a NUM_ROWS x NUM_COLS enemy formation horizontally in fixed point,
// stepping down and reversing at the screen edges, tracks which enemies are
// alive and reports the enemy under the current VGA pixel.
// Ports:
//   clk, resetN      : clock, asynchronous active-low reset
//   startOfFrame     : one-cycle pulse per frame, advances motion
//   pause            : level, freezes motion (hits and drawing keep working)
//   bus (slave)      : pixel in, hit in, draw request / index / offsets out
//   topLeftX/Y       : formation top-left in pixels
//   aliveMask        : bit i = enemy i alive
//   allDead, landed  : terminal status flags
// Optional: define ENEMY_SPEEDUP_EN to add X_SPEED/8 to the horizontal speed
// on every accepted hit, saturating at 4*X_SPEED.
module enemy_formation_move
    import enemy_pkg::*;
#(
    parameter int NUM_COLS        = 6,
    parameter int NUM_ROWS        = 3,
    parameter int OBJECT_WIDTH_X  = 30,
    parameter int OBJECT_HEIGHT_Y = 30,
    parameter int GAP_X           = 10,
    parameter int GAP_Y           = 10,
    parameter int INITIAL_X       = 100,
    parameter int INITIAL_Y       = 40,
    parameter int X_SPEED         = 120,
    parameter int DROP_Y          = 16,
    parameter int SCREEN_W        = 640,
    parameter int LAND_Y          = 420
) (
    input  logic                         clk,
    input  logic                         resetN,
    input  logic                         startOfFrame,
    input  logic                         pause,
    enemy_formation_move_if.slave        bus,
    output logic [10:0]                  topLeftX,
    output logic [10:0]                  topLeftY,
    output logic [NUM_ROWS*NUM_COLS-1:0] aliveMask,
    output logic                         allDead,
    output logic                         landed
);

    localparam int N         = NUM_ROWS * NUM_COLS;
    localparam int PX        = OBJECT_WIDTH_X + GAP_X;
    localparam int PY        = OBJECT_HEIGHT_Y + GAP_Y;
    localparam int INIT_X_FP = INITIAL_X * (1 << FP_SHIFT);
    localparam int INIT_Y_FP = INITIAL_Y * (1 << FP_SHIFT);
    localparam int DROP_FP   = DROP_Y * (1 << FP_SHIFT);
`ifdef ENEMY_SPEEDUP_EN
    localparam int SPEED_INC = X_SPEED / 8;
    localparam int SPEED_MAX = 4 * X_SPEED;
`endif

    state_t             state_q, state_d;
    logic signed [31:0] pos_x_q, pos_x_d;
    logic signed [31:0] pos_y_q, pos_y_d;
    logic signed [31:0] speed_q, speed_d;
    logic               dir_neg_q, dir_neg_d;
    logic [N-1:0]       alive_q, alive_d;

    logic               req_q;
    logic [4:0]         idx_q;
    logic [10:0]        offx_q, offy_q;

    // ---------------- hits ----------------
    logic [N-1:0] hit_vec;
    logic         hit_ok;

    // Out-of-range indices shift the one out of the vector and so never match.
    assign hit_vec = N'(1) << bus.hitIndex;
    assign hit_ok  = bus.hitValid && |(alive_q & hit_vec);
    assign alive_d = hit_ok ? (alive_q & ~hit_vec) : alive_q;

    // Extent follows the post-hit mask so a same-cycle hit shapes this frame's move.
    logic [2:0] min_col, max_col;
    logic [1:0] max_row;
    logic       any_alive;

    enemy_extent #(
        .NUM_ROWS (NUM_ROWS),
        .NUM_COLS (NUM_COLS)
    ) u_extent (
        .aliveMask (alive_d),
        .minCol    (min_col),
        .maxCol    (max_col),
        .maxRow    (max_row),
        .anyAlive  (any_alive)
    );

    // ---------------- motion FSM ----------------
    logic signed [31:0] next_x, next_px, drop_y, drop_py;

    always_comb begin
        state_d   = state_q;
        pos_x_d   = pos_x_q;
        pos_y_d   = pos_y_q;
        dir_neg_d = dir_neg_q;
        speed_d   = speed_q;
        next_x    = pos_x_q + (dir_neg_q ? -speed_q : speed_q);
        next_px   = next_x >>> FP_SHIFT;
        drop_y    = pos_y_q + DROP_FP;
        drop_py   = drop_y >>> FP_SHIFT;

`ifdef ENEMY_SPEEDUP_EN
        if (hit_ok) begin
            speed_d = (speed_q + SPEED_INC > SPEED_MAX) ? SPEED_MAX : speed_q + SPEED_INC;
        end
`endif

        if (!any_alive) begin
            state_d = S_CLEARED;
        end else if (startOfFrame && !pause) begin
            case (state_q)
                S_MOVE: begin
                    if (!dir_neg_q &&
                        next_px + int'(max_col) * PX + OBJECT_WIDTH_X > SCREEN_W) begin
                        state_d = S_DROP;
                    end else if (dir_neg_q && next_px + int'(min_col) * PX < 0) begin
                        state_d = S_DROP;
                    end else begin
                        pos_x_d = next_x;
                    end
                end
                S_DROP: begin
                    pos_y_d   = drop_y;
                    dir_neg_d = !dir_neg_q;
                    state_d   = (drop_py + int'(max_row) * PY + OBJECT_HEIGHT_Y >= LAND_Y) ?
                                S_LANDED : S_MOVE;
                end
                default: ;
            endcase
        end
    end

    // ---------------- drawing ----------------
    logic signed [31:0] tl_x, tl_y, pix_x, pix_y, col_org, row_org;
    logic               col_found, row_found, draw_alive, draw_req;
    logic [2:0]         col_sel;
    logic [1:0]         row_sel;
    logic [4:0]         draw_idx;

    assign tl_x  = pos_x_q >>> FP_SHIFT;
    assign tl_y  = pos_y_q >>> FP_SHIFT;
    assign pix_x = {21'b0, bus.pixelX};
    assign pix_y = {21'b0, bus.pixelY};

    // Boxes never overlap, so at most one column and one row can match.
    always_comb begin
        col_found = 1'b0;
        col_sel   = '0;
        col_org   = '0;
        for (int c = 0; c < NUM_COLS; c++) begin
            if (pix_x >= tl_x + c * PX && pix_x < tl_x + c * PX + OBJECT_WIDTH_X) begin
                col_found = 1'b1;
                col_sel   = 3'(c);
                col_org   = tl_x + c * PX;
            end
        end
        row_found = 1'b0;
        row_sel   = '0;
        row_org   = '0;
        for (int r = 0; r < NUM_ROWS; r++) begin
            if (pix_y >= tl_y + r * PY && pix_y < tl_y + r * PY + OBJECT_HEIGHT_Y) begin
                row_found = 1'b1;
                row_sel   = 2'(r);
                row_org   = tl_y + r * PY;
            end
        end
    end

    assign draw_idx   = 5'(idx(int'(row_sel), int'(col_sel), NUM_COLS));
    assign draw_alive = |(alive_q & (N'(1) << draw_idx));
    assign draw_req   = col_found && row_found && draw_alive;

    // ---------------- registers ----------------
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q   <= S_MOVE;
            pos_x_q   <= INIT_X_FP;
            pos_y_q   <= INIT_Y_FP;
            speed_q   <= X_SPEED;
            dir_neg_q <= 1'b0;
            alive_q   <= '1;
            req_q     <= 1'b0;
            idx_q     <= '0;
            offx_q    <= '0;
            offy_q    <= '0;
        end else begin
            state_q   <= state_d;
            pos_x_q   <= pos_x_d;
            pos_y_q   <= pos_y_d;
            speed_q   <= speed_d;
            dir_neg_q <= dir_neg_d;
            alive_q   <= alive_d;
            req_q     <= draw_req;
            idx_q     <= draw_req ? draw_idx : '0;
            offx_q    <= draw_req ? 11'(pix_x - col_org) : '0;
            offy_q    <= draw_req ? 11'(pix_y - row_org) : '0;
        end
    end

    assign topLeftX           = 11'(tl_x);
    assign topLeftY           = 11'(tl_y);
    assign aliveMask          = alive_q;
    assign allDead            = (state_q == S_CLEARED);
    assign landed             = (state_q == S_LANDED);
    assign bus.drawingRequest = req_q;
    assign bus.enemyIndex     = idx_q;
    assign bus.offsetX        = offx_q;
    assign bus.offsetY        = offy_q;

endmodule
